// File: rtl/cache_pkg.sv
// Shared types and helpers for the MEM-stage cache controller.
//   state_t       controller FSM states (IDLE=0, RD_MISS=1, WR_THRU=2, RESP=3)
//   cache_line_t  one stored line: valid bit, tag (zero-extended to MaxTagW), 32-bit data word
//   calc_idx_w    set-index width for a given number of sets
//   calc_tag_w    tag width for a given byte-address width and number of sets
package cache_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StRdMiss = 2'd1,
        StWrThru = 2'd2,
        StResp   = 2'd3
    } state_t;

    // Stored tags are zero-extended to this width so the line type is parameter-free.
    localparam int unsigned MaxTagW = 32;

    typedef struct packed {
        logic               valid;
        logic [MaxTagW-1:0] tag;
        logic [31:0]        data;
    } cache_line_t;

    function automatic int unsigned calc_idx_w(input int unsigned num_sets);
        return $clog2(num_sets);
    endfunction

    function automatic int unsigned calc_tag_w(input int unsigned addr_w,
                                               input int unsigned num_sets);
        return addr_w - calc_idx_w(num_sets) - 2;
    endfunction

endpackage

// File: rtl/cache_way_array.sv
// One way of the set-associative cache: NumSets x {valid, tag, data}.
//   clk, rst     clock, asynchronous active-high reset (clears valid bits only)
//   inv_all_i    clear every valid bit at the next edge; wins over a same-edge write
//   rd_idx_i     combinational read index
//   rd_line_o    line stored at rd_idx_i
//   we_i         synchronous write enable
//   wr_idx_i     write index
//   wr_line_i    line to store
module cache_way_array
    import cache_pkg::*;
#(
    parameter int unsigned NumSets = 64,
    localparam int unsigned IdxW   = calc_idx_w(NumSets)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inv_all_i,
    input  logic [IdxW-1:0] rd_idx_i,
    output cache_line_t     rd_line_o,
    input  logic            we_i,
    input  logic [IdxW-1:0] wr_idx_i,
    input  cache_line_t     wr_line_i
);

    logic [NumSets-1:0] valid_q;
    logic [MaxTagW-1:0] tag_q  [NumSets];
    logic [31:0]        data_q [NumSets];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else if (inv_all_i) begin
            valid_q <= '0;
        end else if (we_i) begin
            valid_q[wr_idx_i] <= wr_line_i.valid;
        end
    end

    // Tag/data need no reset: they are qualified by valid.
    always_ff @(posedge clk) begin
        if (we_i) begin
            tag_q[wr_idx_i]  <= wr_line_i.tag;
            data_q[wr_idx_i] <= wr_line_i.data;
        end
    end

    always_comb begin
        rd_line_o.valid = valid_q[rd_idx_i];
        rd_line_o.tag   = tag_q[rd_idx_i];
        rd_line_o.data  = data_q[rd_idx_i];
    end

endmodule

// File: rtl/mem_cache_ctrl.sv
// 2-way set-associative, write-through, no-write-allocate cache between the MEM stage
// and an external SRAM. One 32-bit word per line, one LRU bit per set.
//   clk, rst                     clock, asynchronous active-high reset
//   mem_read_en, mem_write_en    load / store request, held while ready=0 (write wins)
//   addr, wdata                  byte address and store data
//   rdata, ready                 load data and request-complete strobe
//   inv_all                      one-cycle pulse clearing every valid bit
//   sram_req/we/addr/wdata       SRAM request, held until sram_ack
//   sram_rdata, sram_ack         SRAM read data and one-cycle completion pulse
//   hit_cnt, miss_cnt            saturating read hit / miss counters
module mem_cache_ctrl
    import cache_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned NUM_SETS = 64,
    parameter int unsigned CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read_en,
    input  logic              mem_write_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              ready,
    input  logic              inv_all,
    output logic              sram_req,
    output logic              sram_we,
    output logic [ADDR_W-3:0] sram_addr,
    output logic [31:0]       sram_wdata,
    input  logic [31:0]       sram_rdata,
    input  logic              sram_ack,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt
);

    localparam int unsigned IdxW = calc_idx_w(NUM_SETS);
    localparam int unsigned TagW = calc_tag_w(ADDR_W, NUM_SETS);

    state_t              state_q, state_d;
    logic [NUM_SETS-1:0] lru_q, lru_d;       // way to evict next in each set
    logic [31:0]         rdata_q, rdata_d;
    logic                sram_req_q, sram_req_d;
    logic                sram_we_q, sram_we_d;
    logic [ADDR_W-3:0]   sram_addr_q, sram_addr_d;
    logic [31:0]         sram_wdata_q, sram_wdata_d;
    logic [CNT_W-1:0]    hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]    miss_cnt_q, miss_cnt_d;

    logic [IdxW-1:0]     req_idx, fill_idx, arr_idx;
    logic [TagW-1:0]     req_tag, fill_tag;
    logic [MaxTagW-1:0]  req_tag_ext, fill_tag_ext;
    cache_line_t         line [2];
    cache_line_t         wr_line;
    logic [1:0]          way_hit, way_we;
    logic                victim;
    logic [31:0]         hit_data;
    logic                unused_addr_bits;

    assign req_idx      = addr[IdxW+1:2];
    assign req_tag      = addr[ADDR_W-1:IdxW+2];
    assign req_tag_ext  = MaxTagW'(req_tag);
    // The fill target comes from the latched SRAM address, not the live request.
    assign fill_idx     = sram_addr_q[IdxW-1:0];
    assign fill_tag     = sram_addr_q[ADDR_W-3:IdxW];
    assign fill_tag_ext = MaxTagW'(fill_tag);
    assign arr_idx      = (state_q == StIdle) ? req_idx : fill_idx;
    assign unused_addr_bits = ^addr[1:0];

    for (genvar w = 0; w < 2; w++) begin : g_way
        cache_way_array #(
            .NumSets (NUM_SETS)
        ) u_way (
            .clk       (clk),
            .rst       (rst),
            .inv_all_i (inv_all),
            .rd_idx_i  (arr_idx),
            .rd_line_o (line[w]),
            .we_i      (way_we[w]),
            .wr_idx_i  (arr_idx),
            .wr_line_i (wr_line)
        );
        assign way_hit[w] = line[w].valid && (line[w].tag == req_tag_ext);
    end

    assign hit_data = way_hit[1] ? line[1].data : line[0].data;
    // Invalid way first (way 0 before way 1), otherwise the LRU way.
    assign victim   = !line[0].valid ? 1'b0 : (!line[1].valid ? 1'b1 : lru_q[fill_idx]);

    always_comb begin
        state_d      = state_q;
        lru_d        = lru_q;
        rdata_d      = rdata_q;
        sram_req_d   = sram_req_q;
        sram_we_d    = sram_we_q;
        sram_addr_d  = sram_addr_q;
        sram_wdata_d = sram_wdata_q;
        hit_cnt_d    = hit_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        way_we       = '0;
        wr_line      = '{valid: 1'b1, tag: req_tag_ext, data: wdata};
        ready        = 1'b0;
        rdata        = rdata_q;

        unique case (state_q)
            StIdle: begin
                if (mem_write_en) begin
                    if (|way_hit) begin
                        way_we         = way_hit;
                        lru_d[req_idx] = ~way_hit[1];
                    end
                    sram_req_d   = 1'b1;
                    sram_we_d    = 1'b1;
                    sram_addr_d  = addr[ADDR_W-1:2];
                    sram_wdata_d = wdata;
                    state_d      = StWrThru;
                end else if (mem_read_en) begin
                    if (|way_hit) begin
                        ready          = 1'b1;
                        rdata          = hit_data;
                        rdata_d        = hit_data;
                        lru_d[req_idx] = ~way_hit[1];
                        if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + CNT_W'(1);
                    end else begin
                        if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + CNT_W'(1);
                        sram_req_d  = 1'b1;
                        sram_we_d   = 1'b0;
                        sram_addr_d = addr[ADDR_W-1:2];
                        state_d     = StRdMiss;
                    end
                end else begin
                    ready = 1'b1;
                end
            end
            StRdMiss: begin
                if (sram_ack) begin
                    way_we[victim]  = 1'b1;
                    wr_line         = '{valid: 1'b1, tag: fill_tag_ext, data: sram_rdata};
                    lru_d[fill_idx] = ~victim;
                    rdata_d         = sram_rdata;
                    sram_req_d      = 1'b0;
                    state_d         = StResp;
                end
            end
            StWrThru: begin
                if (sram_ack) begin
                    sram_req_d = 1'b0;
                    sram_we_d  = 1'b0;
                    state_d    = StResp;
                end
            end
            StResp: begin
                // The still-held request is not re-evaluated here.
                ready   = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            lru_q        <= '0;
            rdata_q      <= '0;
            sram_req_q   <= 1'b0;
            sram_we_q    <= 1'b0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            lru_q        <= lru_d;
            rdata_q      <= rdata_d;
            sram_req_q   <= sram_req_d;
            sram_we_q    <= sram_we_d;
            sram_addr_q  <= sram_addr_d;
            sram_wdata_q <= sram_wdata_d;
            hit_cnt_q    <= hit_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

    assign sram_req   = sram_req_q;
    assign sram_we    = sram_we_q;
    assign sram_addr  = sram_addr_q;
    assign sram_wdata = sram_wdata_q;
    assign hit_cnt    = hit_cnt_q;
    assign miss_cnt   = miss_cnt_q;

    a_no_rd_wr: assert property (@(posedge clk) disable iff (rst)
                                 !(mem_read_en && mem_write_en));

endmodule
